// File: rtl/tiny_io_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tiny_io_arbiter
//  Description : Connects the TinyComp CPU's single input channel to NSRC
//                peripheral sources, and gives its output channel a one-entry
//                buffer toward a sink.
//                Input side: a round-robin arbiter grants one valid source,
//                captures its word and holds it until the CPU consumes it.
//                Output side: a one-entry buffer with a ready/valid handshake.
//                Two sticky flags report CPU protocol errors: Underrun and
//                Overrun.
//  Options     : TINY_IO_FIXED_PRI_EN - when defined, the lowest-indexed
//                valid source always wins and no round-robin pointer is built.
//                The default build (macro undefined) uses round-robin.
//  Ports       : Ph0        - clock; all state changes on the rising edge
//                Reset_n    - synchronous, active-low reset
//                SrcData    - source words; source k at [k*DW +: DW]
//                SrcValid   - source k has a word available
//                SrcReady   - one-cycle pulse: source k's word was captured
//                InData     - held word presented to the CPU
//                InRdy      - the held word is valid
//                InSrc      - index of the source that supplied InData
//                InStrobe   - CPU consumes the held word
//                OutData    - CPU output word
//                OutStrobe  - CPU executes an Output instruction
//                SinkData   - buffered output word
//                SinkValid  - the output buffer is full
//                SinkReady  - the sink accepts SinkData
//                Underrun   - sticky: InStrobe arrived with no word held
//                Overrun    - sticky: OutStrobe arrived into a full buffer
//                             that was not draining
//  Revision    : 1.0 - initial release
// ============================================================================
module tiny_io_arbiter #(
    parameter int NSRC = 4,
    parameter int DW   = 32,
    parameter int SW   = 3
) (
    input  logic                Ph0,
    input  logic                Reset_n,
    input  logic [NSRC*DW-1:0]  SrcData,
    input  logic [NSRC-1:0]     SrcValid,
    output logic [NSRC-1:0]     SrcReady,
    output logic [DW-1:0]       InData,
    output logic                InRdy,
    output logic [SW-1:0]       InSrc,
    input  logic                InStrobe,
    input  logic [DW-1:0]       OutData,
    input  logic                OutStrobe,
    output logic [DW-1:0]       SinkData,
    output logic                SinkValid,
    input  logic                SinkReady,
    output logic                Underrun,
    output logic                Overrun
);

    // The source index must be able to name every source.
    generate
        if ((1 << SW) < NSRC) begin : g_param_check
            $error("tiny_io_arbiter: SW too narrow for NSRC");
        end
    endgenerate

    // The valid vector is padded to 2**SW bits so that an SW-bit index
    // selects from it at exactly the right width.
    localparam int NPAD = 1 << SW;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;

    logic [NPAD-1:0]    w_valid_pad;
    logic [SW-1:0]      w_start;
    logic [SW-1:0]      w_scan_idx;
    logic [SW-1:0]      w_grant_idx;
    logic               w_grant_any;
    logic [DW-1:0]      w_grant_data;
    logic [NSRC-1:0]    w_grant_onehot;
    logic               w_grant;
    logic               w_consume;

    logic [DW-1:0]      r_in_data;
    logic [SW-1:0]      r_in_src;
    logic [NSRC-1:0]    r_src_ready;
    logic               r_underrun;

    logic [DW-1:0]      r_sink_data;
    logic               r_sink_valid;
    logic               r_overrun;
    logic               w_out_accept;
    logic               w_out_drop;

    // ------------------------------------------------------------------
    // Search start point: the round-robin pointer, or always 0 for fixed
    // priority.
    // ------------------------------------------------------------------
`ifdef TINY_IO_FIXED_PRI_EN
    assign w_start = '0;
`else
    logic [SW-1:0] r_ptr;
    logic [SW-1:0] w_src_next;

    // The next search starts just after the source that was just consumed,
    // wrapping at NSRC rather than at 2**SW.
    assign w_src_next = (r_in_src == SW'(NSRC - 1)) ? '0 : r_in_src + 1'b1;
    assign w_start    = r_ptr;

    always_ff @(posedge Ph0) begin
        if (!Reset_n) begin
            r_ptr <= '0;
        end else if (w_consume) begin
            r_ptr <= w_src_next;
        end
    end
`endif

    // ------------------------------------------------------------------
    // Find the first valid source at or after w_start, modulo NSRC.
    // ------------------------------------------------------------------
    always_comb begin
        w_valid_pad             = '0;
        w_valid_pad[NSRC-1:0]   = SrcValid;
        w_grant_any             = 1'b0;
        w_grant_idx             = '0;
        w_scan_idx              = w_start;
        for (int k = 0; k < NSRC; k++) begin
            if (!w_grant_any && w_valid_pad[w_scan_idx]) begin
                w_grant_any = 1'b1;
                w_grant_idx = w_scan_idx;
            end
            w_scan_idx = (w_scan_idx == SW'(NSRC - 1)) ? '0 : w_scan_idx + 1'b1;
        end
    end

    // Select the winning source's word and build its one-hot ready mask.
    always_comb begin
        w_grant_data   = '0;
        w_grant_onehot = '0;
        for (int k = 0; k < NSRC; k++) begin
            if (w_grant_idx == SW'(k)) begin
                w_grant_data      = SrcData[k*DW +: DW];
                w_grant_onehot[k] = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Input FSM
    // ------------------------------------------------------------------
    always_ff @(posedge Ph0) begin
        if (!Reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_grant     = 1'b0;
        w_consume   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_grant_any) begin
                    w_grant     = 1'b1;
                    w_state_nxt = ST_HOLD;
                end
            end
            ST_HOLD: begin
                // SrcValid is ignored here; only the CPU can release the word.
                if (InStrobe) begin
                    w_consume   = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Input datapath: capture the word, pulse the source, flag underruns.
    always_ff @(posedge Ph0) begin
        if (!Reset_n) begin
            r_in_data   <= '0;
            r_in_src    <= '0;
            r_src_ready <= '0;
            r_underrun  <= 1'b0;
        end else begin
            r_src_ready <= w_grant ? w_grant_onehot : '0;
            if (w_grant) begin
                r_in_data <= w_grant_data;
                r_in_src  <= w_grant_idx;
            end
            if (InStrobe && (r_state == ST_IDLE)) begin
                r_underrun <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Output buffer: one entry. A word is accepted if the buffer is empty
    // or is draining on this same edge, so a full buffer can be refilled
    // without a bubble.
    // ------------------------------------------------------------------
    assign w_out_accept = OutStrobe && (!r_sink_valid || SinkReady);
    assign w_out_drop   = OutStrobe && r_sink_valid && !SinkReady;

    always_ff @(posedge Ph0) begin
        if (!Reset_n) begin
            r_sink_data  <= '0;
            r_sink_valid <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            if (w_out_accept) begin
                r_sink_data  <= OutData;
                r_sink_valid <= 1'b1;
            end else if (r_sink_valid && SinkReady) begin
                r_sink_valid <= 1'b0;
            end
            if (w_out_drop) begin
                r_overrun <= 1'b1;
            end
        end
    end

    assign InData    = r_in_data;
    assign InRdy     = (r_state == ST_HOLD);
    assign InSrc     = r_in_src;
    assign SrcReady  = r_src_ready;
    assign Underrun  = r_underrun;
    assign SinkData  = r_sink_data;
    assign SinkValid = r_sink_valid;
    assign Overrun   = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_tiny_io_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_tiny_io_arbiter
//  Description : Self-checking bench for tiny_io_arbiter. A behavioural model
//                runs alongside the DUT and is compared against it every
//                cycle. Directed sequences pin the model with literal values.
//                A randomized phase then exercises the protocol.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_tiny_io_arbiter;

    localparam int NSRC = 4;
    localparam int DW   = 32;
    localparam int SW   = 3;

    logic                Ph0;
    logic                Reset_n;
    logic [NSRC*DW-1:0]  SrcData;
    logic [NSRC-1:0]     SrcValid;
    logic [NSRC-1:0]     SrcReady;
    logic [DW-1:0]       InData;
    logic                InRdy;
    logic [SW-1:0]       InSrc;
    logic                InStrobe;
    logic [DW-1:0]       OutData;
    logic                OutStrobe;
    logic [DW-1:0]       SinkData;
    logic                SinkValid;
    logic                SinkReady;
    logic                Underrun;
    logic                Overrun;

    int n_checks = 0;
    int n_errors = 0;

    tiny_io_arbiter #(.NSRC(NSRC), .DW(DW), .SW(SW)) dut (
        .Ph0       (Ph0),
        .Reset_n   (Reset_n),
        .SrcData   (SrcData),
        .SrcValid  (SrcValid),
        .SrcReady  (SrcReady),
        .InData    (InData),
        .InRdy     (InRdy),
        .InSrc     (InSrc),
        .InStrobe  (InStrobe),
        .OutData   (OutData),
        .OutStrobe (OutStrobe),
        .SinkData  (SinkData),
        .SinkValid (SinkValid),
        .SinkReady (SinkReady),
        .Underrun  (Underrun),
        .Overrun   (Overrun)
    );

    initial Ph0 = 1'b0;
    always #5 Ph0 = ~Ph0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model: one held word (or none), a next-search start
    // index, and a one-slot output buffer, advanced once per clock edge.
    // ------------------------------------------------------------------
    bit              m_hold;
    logic [DW-1:0]   m_data;
    int              m_src;
    int              m_ptr;
    int              m_pulse;
    bit              m_under;
    bit              m_over;
    bit              m_sv;
    logic [DW-1:0]   m_sd;
    int              mt_start;
    int              mt_i;
    logic [NSRC-1:0] mt_rdy;

    always @(posedge Ph0) begin
        if (!Reset_n) begin
            m_hold = 0; m_data = '0; m_src = 0; m_ptr = 0; m_pulse = -1;
            m_under = 0; m_over = 0; m_sv = 0; m_sd = '0;
        end else begin
            m_pulse = -1;
            if (!m_hold) begin
                if (InStrobe) m_under = 1;
`ifdef TINY_IO_FIXED_PRI_EN
                mt_start = 0;
`else
                mt_start = m_ptr;
`endif
                for (int k = 0; k < NSRC; k++) begin
                    mt_i = (mt_start + k) % NSRC;
                    if (m_pulse < 0 && SrcValid[mt_i]) begin
                        m_pulse = mt_i;
                        m_hold  = 1;
                        m_src   = mt_i;
                        m_data  = SrcData[mt_i*DW +: DW];
                    end
                end
            end else if (InStrobe) begin
                m_hold = 0;
                m_ptr  = (m_src + 1) % NSRC;
            end
            if (OutStrobe) begin
                if (!m_sv || SinkReady) begin
                    m_sd = OutData;
                    m_sv = 1;
                end else begin
                    m_over = 1;
                end
            end else if (m_sv && SinkReady) begin
                m_sv = 0;
            end
        end
        mt_rdy = '0;
        if (m_pulse >= 0) mt_rdy[m_pulse] = 1'b1;
        #1;
        check("m_InRdy",     InRdy,     m_hold);
        check("m_InData",    InData,    m_data);
        check("m_InSrc",     InSrc,     m_src);
        check("m_SrcReady",  SrcReady,  mt_rdy);
        check("m_Underrun",  Underrun,  m_under);
        check("m_SinkValid", SinkValid, m_sv);
        check("m_SinkData",  SinkData,  m_sd);
        check("m_Overrun",   Overrun,   m_over);
    end

    // Watchdog
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1, "timeout");
    end

    int exp_rr[5];
    int w;

    initial begin
`ifdef TINY_IO_FIXED_PRI_EN
        exp_rr = '{0, 0, 0, 0, 0};
`else
        exp_rr = '{0, 1, 2, 3, 0};
`endif
        // Reset with every source valid and the CPU strobing its output.
        Reset_n   = 1'b0;
        SrcValid  = '1;
        for (int k = 0; k < NSRC; k++) SrcData[k*DW +: DW] = 32'hA000_0000 + k;
        InStrobe  = 1'b0;
        OutData   = 32'hFFFF_FFFF;
        OutStrobe = 1'b1;
        SinkReady = 1'b0;
        repeat (2) @(negedge Ph0);
        check("rst_InRdy",     InRdy,     0);
        check("rst_InData",    InData,    0);
        check("rst_InSrc",     InSrc,     0);
        check("rst_SrcReady",  SrcReady,  0);
        check("rst_SinkValid", SinkValid, 0);
        check("rst_SinkData",  SinkData,  0);
        check("rst_Underrun",  Underrun,  0);
        check("rst_Overrun",   Overrun,   0);
        Reset_n   = 1'b1;
        OutStrobe = 1'b0;

        // Round-robin: all sources valid, the CPU consumes each word at once.
        for (int g = 0; g < 5; g++) begin
            w = 0;
            while (!InRdy && w < 10) begin
                @(negedge Ph0);
                w++;
            end
            check("rr_latency", w, 1);
            check("rr_src",     InSrc, exp_rr[g]);
            check("rr_pulse",   SrcReady, 64'd1 << exp_rr[g]);
            check("rr_data",    InData, 32'hA000_0000 + exp_rr[g]);
            InStrobe = 1'b1;
            @(negedge Ph0);
            InStrobe = 1'b0;
            check("rr_consume", InRdy, 0);
        end

        // Single source
        SrcValid = 4'b0100;
        SrcData[2*DW +: DW] = 32'hDEADBEEF;
        @(negedge Ph0);
        check("single_rdy",   InRdy,    1);
        check("single_data",  InData,   32'hDEADBEEF);
        check("single_src",   InSrc,    2);
        check("single_pulse", SrcReady, 4'b0100);
        SrcValid = '0;
        @(negedge Ph0);
        check("single_pulse_end", SrcReady, 0);
        check("single_hold",      InRdy,    1);
        InStrobe = 1'b1;
        @(negedge Ph0);
        check("single_drop", InRdy,    0);
        check("no_underrun", Underrun, 0);

        // Underrun: keep strobing in IDLE with nothing valid.
        @(negedge Ph0);
        check("underrun_set", Underrun, 1);
        check("underrun_rdy", InRdy,    0);
        InStrobe = 1'b0;
        SrcValid = 4'b0001;
        SrcData[0*DW +: DW] = 32'h1111_1111;
        @(negedge Ph0);
        check("after_ur_rdy",  InRdy,  1);
        check("after_ur_data", InData, 32'h1111_1111);
        check("after_ur_src",  InSrc,  0);
        SrcValid = '0;
        InStrobe = 1'b1;
        @(negedge Ph0);
        InStrobe = 1'b0;
        check("after_ur_drop",  InRdy,    0);
        check("underrun_stays", Underrun, 1);

        // Output buffer, overrun, drain
        OutStrobe = 1'b1;
        OutData   = 32'h12345678;
        @(negedge Ph0);
        check("out_valid", SinkValid, 1);
        check("out_data",  SinkData,  32'h12345678);
        OutData = 32'hAAAA5555;
        @(negedge Ph0);
        OutStrobe = 1'b0;
        check("ovr_set",  Overrun,  1);
        check("ovr_data", SinkData, 32'h12345678);
        SinkReady = 1'b1;
        @(negedge Ph0);
        SinkReady = 1'b0;
        check("drain_valid", SinkValid, 0);

        // Pass-through after a fresh reset
        Reset_n = 1'b0;
        @(negedge Ph0);
        check("rst2_Overrun",  Overrun,  0);
        check("rst2_Underrun", Underrun, 0);
        Reset_n   = 1'b1;
        OutStrobe = 1'b1;
        OutData   = 32'h0000_0001;
        @(negedge Ph0);
        OutData   = 32'h0000_0007;
        SinkReady = 1'b1;
        @(negedge Ph0);
        check("pt_valid",   SinkValid, 1);
        check("pt_data",    SinkData,  32'h0000_0007);
        check("pt_overrun", Overrun,   0);
        OutStrobe = 1'b0;
        SinkReady = 1'b0;

        // Randomized protocol-respecting traffic with occasional resets.
        repeat (2000) begin
            @(negedge Ph0);
            Reset_n = ($urandom_range(0, 299) != 0);
            for (int k = 0; k < NSRC; k++) begin
                if (SrcValid[k] && SrcReady[k]) begin
                    if ($urandom_range(0, 1) == 1) SrcData[k*DW +: DW] = $urandom;
                    else                           SrcValid[k] = 1'b0;
                end else if (!SrcValid[k] && $urandom_range(0, 3) == 0) begin
                    SrcValid[k] = 1'b1;
                    SrcData[k*DW +: DW] = $urandom;
                end
            end
            InStrobe  = InRdy ? ($urandom_range(0, 9) < 7) : ($urandom_range(0, 19) == 0);
            OutStrobe = ($urandom_range(0, 9) < 4);
            OutData   = $urandom;
            SinkReady = ($urandom_range(0, 1) == 1);
        end
        @(negedge Ph0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
